// File: rtl/mips_pkg.sv
// Shared definitions for the EX/MEM/WB pipeline control slice of the
// 5-stage MIPS core.
//   - FWD_REG / FWD_WB / FWD_MEM : EX-stage forwarding select encodings
//   - mem_state_e                : MEM-stage data-memory sequencer states
//   - fwd_sel()                  : forwarding select for one EX source operand
package mips_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_DONE = 2'd2
  } mem_state_e;

  // MEM is the younger producer, so it wins over WB.
  // Register $0 is hard-wired to zero and is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic       regWriteM,
                                         input logic [4:0] writeRegM,
                                         input logic       regWriteW,
                                         input logic [4:0] writeRegW,
                                         input logic [4:0] srcReg);
    if (regWriteM && (writeRegM != 5'd0) && (writeRegM == srcReg))
      return FWD_MEM;
    else if (regWriteW && (writeRegW != 5'd0) && (writeRegW == srcReg))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_hazard.sv
// hazard_detect: purely combinational hazard and forwarding logic.
// Ports:
//   mem_busy_i               MEM stage is waiting on data memory
//   MemToReg_E_i/WriteReg_E_i EX-stage load flag and destination
//   Rs_D_i/Rt_D_i            ID-stage sources
//   Rs_E_i/Rt_E_i            EX-stage sources
//   RegWrite_M_i/WriteReg_M_i, RegWrite_W_i/WriteReg_W_i  producers
//   branch_D_i               branch taken in ID
//   stall_F_o..stall_M_o     hold pipeline registers
//   flush_D_o/E_o/W_o        insert bubbles
//   ForwardA_E_o/B_E_o       EX operand forwarding selects
import mips_pkg::*;

module hazard_detect (
  input  logic       mem_busy_i,
  input  logic       MemToReg_E_i,
  input  logic [4:0] WriteReg_E_i,
  input  logic [4:0] Rs_D_i,
  input  logic [4:0] Rt_D_i,
  input  logic [4:0] Rs_E_i,
  input  logic [4:0] Rt_E_i,
  input  logic       RegWrite_M_i,
  input  logic [4:0] WriteReg_M_i,
  input  logic       RegWrite_W_i,
  input  logic [4:0] WriteReg_W_i,
  input  logic       branch_D_i,
  output logic       stall_F_o,
  output logic       stall_D_o,
  output logic       stall_E_o,
  output logic       stall_M_o,
  output logic       flush_D_o,
  output logic       flush_E_o,
  output logic       flush_W_o,
  output logic [1:0] ForwardA_E_o,
  output logic [1:0] ForwardB_E_o
);

  logic loadUse;
  logic loadUseAct;

  // A load in EX feeding an ID source must wait one cycle for its data.
  assign loadUse = MemToReg_E_i && (WriteReg_E_i != 5'd0) &&
                   ((WriteReg_E_i == Rs_D_i) || (WriteReg_E_i == Rt_D_i));

  // A memory stall freezes everything, so load-use/branch effects wait.
  assign loadUseAct = loadUse && !mem_busy_i;

  assign stall_F_o = mem_busy_i || loadUseAct;
  assign stall_D_o = mem_busy_i || loadUseAct;
  assign stall_E_o = mem_busy_i;
  assign stall_M_o = mem_busy_i;
  // WB gets a bubble each stalled cycle so a register write is not repeated.
  assign flush_W_o = mem_busy_i;
  assign flush_E_o = loadUseAct;
  assign flush_D_o = branch_D_i && !loadUse && !mem_busy_i;

  assign ForwardA_E_o = fwd_sel(RegWrite_M_i, WriteReg_M_i, RegWrite_W_i, WriteReg_W_i, Rs_E_i);
  assign ForwardB_E_o = fwd_sel(RegWrite_M_i, WriteReg_M_i, RegWrite_W_i, WriteReg_W_i, Rt_E_i);

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: EX/MEM/WB pipeline controller.
// Sequences MEM-stage data-memory accesses over a req/ack handshake
// (IDLE -> WAIT -> DONE -> IDLE), aborts after TIMEOUT unanswered WAIT
// cycles with a sticky bus_err, counts memory-stall cycles, and hosts
// hazard_detect for load-use stalls, branch flush and forwarding.
// Ports: MEM-stage request (MemRead_M/MemWrite_M/ALUout_M/WriteData_M),
// hazard inputs (RegWrite/WriteReg for E/M/W, Rs/Rt for D/E, branch_D),
// memory bus (dmem_*), ReadData_M, stall_*/flush_*, ForwardA_E/B_E,
// bus_err and stall_cnt.
import mips_pkg::*;

module mem_stage_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead_M,
  input  logic             MemWrite_M,
  input  logic [AW-1:0]    ALUout_M,
  input  logic [DW-1:0]    WriteData_M,
  input  logic             RegWrite_M,
  input  logic [4:0]       WriteReg_M,
  input  logic             RegWrite_W,
  input  logic [4:0]       WriteReg_W,
  input  logic             MemToReg_E,
  input  logic [4:0]       WriteReg_E,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic [4:0]       Rs_E,
  input  logic [4:0]       Rt_E,
  input  logic             branch_D,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [AW-1:0]    dmem_addr,
  output logic [DW-1:0]    dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DW-1:0]    dmem_rdata,
  output logic [DW-1:0]    ReadData_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  mem_state_e       state_q;
  logic             req_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;
  logic             busErr_q;
  logic [TW-1:0]    tmo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             memBusy;

  // The request cycle in IDLE already stalls, giving the 2-cycle minimum.
  assign memBusy = (state_q == MS_WAIT) ||
                   ((state_q == MS_IDLE) && (MemRead_M || MemWrite_M));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MS_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      busErr_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (MemRead_M || MemWrite_M) begin
            addr_q  <= ALUout_M;
            wdata_q <= WriteData_M;
            we_q    <= MemWrite_M;
            req_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= MS_WAIT;
          end
        end
        MS_WAIT: begin
          // An ack on the final allowed cycle still counts as success.
          if (dmem_ack) begin
            if (!we_q) rdata_q <= dmem_rdata;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= MS_DONE;
          end else if (tmo_q == TMO_LAST) begin
            busErr_q <= 1'b1;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            state_q  <= MS_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        MS_DONE: state_q <= MS_IDLE;
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  // Saturating count of cycles the pipeline spent frozen on memory.
  always_comb begin
    cnt_d = cnt_q;
    if (memBusy && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign ReadData_M = rdata_q;
  assign bus_err    = busErr_q;
  assign stall_cnt  = cnt_q;

  hazard_detect u_hazard (
    .mem_busy_i   (memBusy),
    .MemToReg_E_i (MemToReg_E),
    .WriteReg_E_i (WriteReg_E),
    .Rs_D_i       (Rs_D),
    .Rt_D_i       (Rt_D),
    .Rs_E_i       (Rs_E),
    .Rt_E_i       (Rt_E),
    .RegWrite_M_i (RegWrite_M),
    .WriteReg_M_i (WriteReg_M),
    .RegWrite_W_i (RegWrite_W),
    .WriteReg_W_i (WriteReg_W),
    .branch_D_i   (branch_D),
    .stall_F_o    (stall_F),
    .stall_D_o    (stall_D),
    .stall_E_o    (stall_E),
    .stall_M_o    (stall_M),
    .flush_D_o    (flush_D),
    .flush_E_o    (flush_E),
    .flush_W_o    (flush_W),
    .ForwardA_E_o (ForwardA_E),
    .ForwardB_E_o (ForwardB_E)
  );

endmodule
